mfe_window_fetch: RTL

Front-end stage of the median filter engine (MFE). Scans a 128x128 8-bit grey-scale image in raster order through the image-ROM port (`iaddr`/`idata`), keeps a sliding 3x3 neighbourhood and delivers one zero-padded window per output pixel to the median sorter core. Sorter backpressure is handled by a valid/ready handshake. Job start follows the MFE `busy`/`ready` protocol.

---
 rtl/mfe_window_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mfe_window_fetch.sv
// mfe_window_fetch: raster-scans the image ROM and presents one zero-padded 3x3
// window per pixel to the median sorter over a valid/ready handshake.
module mfe_window_fetch #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [7:0]    idata,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [71:0]   win_data,
    output logic [AW-1:0] win_addr
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = AW - CW;

    typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [2:0]    k_q, k_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic          busy_q, valid_q;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [2:0]    iss_j, cap_j;
    logic [3:0]    cap_p;
    logic          first, accept, last, issue;

    // Slot j of a fetch: rows r-1,r,r+1 in order; column 0 fetches loop twice (cols 0 and 1).
    function automatic logic [1:0] slot_row(input logic [2:0] j);
        return (j >= 3'd3) ? 2'(j - 3'd3) : j[1:0];
    endfunction

    function automatic logic slot_off(input logic [2:0] j, input logic [CW-1:0] c);
        return (c != '0) || (j >= 3'd3);
    endfunction

    function automatic logic slot_oob(input logic [2:0] j, input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (slot_row(j) == 2'd0 && r == '0) ||
               (slot_row(j) == 2'd2 && r == RW'(IMG_H - 1)) ||
               (slot_off(j, c) && c == CW'(IMG_W - 1));
    endfunction

    function automatic logic [AW-1:0] slot_addr(input logic [2:0] j, input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [RW-1:0] row;
        row = r + RW'(slot_row(j)) - RW'(1);
        return {row, c + CW'(slot_off(j, c))};
    endfunction

    function automatic logic [3:0] slot_pos(input logic [2:0] j, input logic fst);
        return 4'(slot_row(j)) * 4'd3 + ((fst && j < 3'd3) ? 4'd1 : 4'd2);
    endfunction

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        iaddr_d = iaddr_q;
        win_d   = win_q;
        first   = c_q == '0;
        accept  = valid_q & win_ready;
        last    = {r_q, c_q} == AW'(IMG_W * IMG_H - 1);
        issue   = 1'b0;
        iss_j   = k_q + 3'd1;
        cap_j   = k_q - 3'd1;
        cap_p   = slot_pos(cap_j, first);
        case (state_q)
            IDLE: if (ready) begin
                state_d = FETCH;
                r_d     = '0;
                c_d     = '0;
                k_d     = '0;
                win_d   = '{default: '0};
                issue   = 1'b1;
                iss_j   = '0;
            end
            FETCH: begin
                // Data for the slot issued last cycle arrives now; padding slots write zero.
                if (k_q != '0) win_d[cap_p] = slot_oob(cap_j, r_q, c_q) ? 8'h00 : idata;
                k_d   = k_q + 3'd1;
                issue = k_q < (first ? 3'd5 : 3'd2);
                if (k_q == (first ? 3'd6 : 3'd3)) state_d = OUT;
            end
            OUT: if (accept) begin
                c_d     = c_q + CW'(1);
                r_d     = (c_q == CW'(IMG_W - 1)) ? r_q + RW'(1) : r_q;
                k_d     = '0;
                state_d = last ? DONE : FETCH;
                issue   = !last;
                iss_j   = '0;
                for (int i = 0; i < 3; i++) begin
                    win_d[3*i]   = win_q[3*i+1];
                    win_d[3*i+1] = win_q[3*i+2];
                    win_d[3*i+2] = 8'h00;
                end
                if (c_q == CW'(IMG_W - 1)) win_d = '{default: '0};
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue && !slot_oob(iss_j, r_d, c_d)) iaddr_d = slot_addr(iss_j, r_d, c_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            iaddr_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            iaddr_q <= iaddr_d;
            busy_q  <= state_d != IDLE;
            valid_q <= state_d == OUT;
            win_q   <= win_d;
        end
    end

    assign busy      = busy_q;
    assign iaddr     = iaddr_q;
    assign win_valid = valid_q;
    assign win_addr  = {r_q, c_q};
    assign win_data  = {win_q[0], win_q[1], win_q[2], win_q[3], win_q[4],
                        win_q[5], win_q[6], win_q[7], win_q[8]};
endmodule
